// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared encodings for the cache/main-memory arbiter.
// Memory command/status codes, data types and arbiter states.
package mem_arbiter_ctrl_pkg;

    localparam logic [1:0] MEM_NOP     = 2'd0;
    localparam logic [1:0] MEM_READ    = 2'd1;
    localparam logic [1:0] MEM_WRITE   = 2'd2;

    localparam logic [1:0] MEM_RESTING = 2'd0;
    localparam logic [1:0] MEM_DONE    = 2'd1;

    localparam logic [2:0] ONE_BYTE    = 3'd1;
    localparam logic [2:0] TWO_BYTE    = 3'd2;
    localparam logic [2:0] FOUR_BYTE   = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    // Zero-length requests still move one beat; long ones clamp to a line.
    function automatic int eff_beats(input int n, input int max_n);
        if (n == 0) return 1;
        if (n > max_n) return max_n;
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Main-memory port bundle driven by the arbiter.
// master = arbiter side, slave = memory side.
interface mem_arbiter_ctrl_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int LEN_W      = 4
);
    logic [1:0]            mem_i_signal;
    logic [1:0]            mem_d_signal;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LEN-1:0]        mem_wdata;
    logic [2:0]            mem_data_type;
    logic [LEN_W-1:0]      mem_length;
    logic [LEN-1:0]        mem_rdata;
    logic [1:0]            mem_status;

    modport master (
        output mem_i_signal, mem_d_signal, mem_addr,
        output mem_wdata, mem_data_type, mem_length,
        input  mem_rdata, mem_status
    );

    modport slave (
        input  mem_i_signal, mem_d_signal, mem_addr,
        input  mem_wdata, mem_data_type, mem_length,
        output mem_rdata, mem_status
    );
endinterface

// File: rtl/mem_arbiter_ctrl_pick.sv
// Grant decision and starve-counter update for the arbiter.
// Purely combinational so the policy can be exercised on its own.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 3
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_i,
    output logic          grant_d,
    output logic [SW-1:0] starve_nxt
);
    logic at_limit;

    assign at_limit = (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        grant_i    = i_req && (!d_req || at_limit);
        grant_d    = d_req && !grant_i;
        starve_nxt = starve_cnt;
        if (grant_i)
            starve_nxt = '0;
        else if (grant_d && i_req && !at_limit)
            starve_nxt = starve_cnt + SW'(1);
    end
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates i/d-cache line requests onto main memory,
// one 4-byte beat every two cycles.
module mem_arbiter_ctrl #(
    parameter int ADDR_WIDTH   = 17,
    parameter int LEN          = 32,
    parameter int LINE_WORDS   = 8,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [LEN_W-1:0]           i_len,
    output logic [LINE_WORDS*LEN-1:0]  i_rdata,
    output logic                       i_done,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [ADDR_WIDTH-1:0]      d_addr,
    input  logic [LEN_W-1:0]           d_len,
    input  logic [2:0]                 d_data_type,
    input  logic [LINE_WORDS*LEN-1:0]  d_wdata,
    output logic [LINE_WORDS*LEN-1:0]  d_rdata,
    output logic                       d_done,
    mem_arbiter_ctrl_if.master         mem
);
    import mem_arbiter_ctrl_pkg::*;

    localparam int IW = $clog2(LINE_WORDS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t                state;
    logic                      own_i;
    logic                      wr;
    logic [ADDR_WIDTH-1:0]     base;
    logic [LEN_W-1:0]          len;
    logic [LEN_W-1:0]          beat;
    logic [LINE_WORDS*LEN-1:0] wbuf;
    logic [1:0]                i_cmd;
    logic [1:0]                d_cmd;
    logic [SW-1:0]             starve;

    logic                      grant_i;
    logic                      grant_d;
    logic [SW-1:0]             starve_nxt;
    logic [LEN_W-1:0]          g_len;
    logic [2:0]                g_dt;
    logic [LEN_W-1:0]          beat_nx;
    logic [IW-1:0]             slot;
    logic [IW-1:0]             nslot;
    logic [ADDR_WIDTH-1:0]     nxt_addr;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve),
        .grant_i    (grant_i),
        .grant_d    (grant_d),
        .starve_nxt (starve_nxt)
    );

    assign g_len    = LEN_W'(eff_beats(int'(grant_i ? i_len : d_len),
                                       LINE_WORDS));
    // Only single-beat writes honour the requested width.
    assign g_dt     = (grant_d && d_we && g_len == LEN_W'(1))
                    ? d_data_type : FOUR_BYTE;
    assign beat_nx  = beat + LEN_W'(1);
    assign slot     = beat[IW-1:0];
    assign nslot    = beat_nx[IW-1:0];
    assign nxt_addr = base + ADDR_WIDTH'({beat_nx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ARB_IDLE;
            own_i             <= 1'b0;
            wr                <= 1'b0;
            base              <= '0;
            len               <= '0;
            beat              <= '0;
            wbuf              <= '0;
            i_cmd             <= MEM_NOP;
            d_cmd             <= MEM_NOP;
            starve            <= '0;
            i_rdata           <= '0;
            d_rdata           <= '0;
            i_done            <= 1'b0;
            d_done            <= 1'b0;
            mem.mem_i_signal  <= MEM_NOP;
            mem.mem_d_signal  <= MEM_NOP;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_data_type <= '0;
            mem.mem_length    <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (grant_i || grant_d) begin
                        own_i             <= grant_i;
                        wr                <= grant_d && d_we;
                        base              <= grant_i ? i_addr : d_addr;
                        len               <= g_len;
                        beat              <= '0;
                        wbuf              <= d_wdata;
                        starve            <= starve_nxt;
                        i_cmd             <= grant_i ? MEM_READ : MEM_NOP;
                        d_cmd             <= !grant_d ? MEM_NOP
                                           : (d_we ? MEM_WRITE : MEM_READ);
                        mem.mem_i_signal  <= grant_i ? MEM_READ : MEM_NOP;
                        mem.mem_d_signal  <= !grant_d ? MEM_NOP
                                           : (d_we ? MEM_WRITE : MEM_READ);
                        mem.mem_addr      <= grant_i ? i_addr : d_addr;
                        mem.mem_wdata     <= d_wdata[LEN-1:0];
                        mem.mem_data_type <= g_dt;
                        mem.mem_length    <= g_len;
                        state             <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    mem.mem_i_signal <= MEM_NOP;
                    mem.mem_d_signal <= MEM_NOP;
                    state            <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem.mem_status != MEM_RESTING) begin
                        if (!wr && own_i)
                            i_rdata[LEN*slot +: LEN] <= mem.mem_rdata;
                        if (!wr && !own_i)
                            d_rdata[LEN*slot +: LEN] <= mem.mem_rdata;
                        beat <= beat_nx;
                        if (beat_nx < len) begin
                            mem.mem_i_signal <= i_cmd;
                            mem.mem_d_signal <= d_cmd;
                            mem.mem_addr     <= nxt_addr;
                            mem.mem_wdata    <= wbuf[LEN*nslot +: LEN];
                            state            <= ARB_ISSUE;
                        end else begin
                            i_done <= own_i;
                            d_done <= !own_i;
                            state  <= ARB_DONE;
                        end
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Randomised scoreboard bench for mem_arbiter_ctrl with a byte-array
// main memory and a shadow memory as reference.
module tb_mem_arbiter_ctrl;
    import mem_arbiter_ctrl_pkg::*;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int LW = 8;

    typedef struct {
        bit              we;
        int              beats;
        logic [AW-1:0]   addr;
        logic [2:0]      dt;
        logic [LW*DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [2:0]    dt;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_req = 1'b0;
    logic [AW-1:0]    i_addr = '0;
    logic [3:0]       i_len = '0;
    logic [LW*DW-1:0] i_rdata;
    logic             i_done;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [AW-1:0]    d_addr = '0;
    logic [3:0]       d_len = '0;
    logic [2:0]       d_data_type = '0;
    logic [LW*DW-1:0] d_wdata = '0;
    logic [LW*DW-1:0] d_rdata;
    logic             d_done;

    mem_arbiter_ctrl_if mif ();

    mem_arbiter_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_len       (i_len),
        .i_rdata     (i_rdata),
        .i_done      (i_done),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_len       (d_len),
        .d_data_type (d_data_type),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    logic [7:0] store  [0:(1<<AW)-1];
    logic [7:0] shadow [0:(1<<AW)-1];
    exp_t       exp_i[$];
    exp_t       exp_d[$];
    cmd_t       cmd_log[$];
    string      order = "";
    int         errors = 0;
    int         checks = 0;

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input int off);
        return a + AW'(off);
    endfunction

    function automatic int beats_of(input logic [3:0] n);
        if (n == 0) return 1;
        if (n > 8) return 8;
        return int'(n);
    endfunction

    function automatic int bytes_of(input logic [2:0] dt);
        if (dt == ONE_BYTE) return 1;
        if (dt == TWO_BYTE) return 2;
        return 4;
    endfunction

    function automatic logic [LW*DW-1:0] line_of(input logic [AW-1:0] a, input int b);
        logic [LW*DW-1:0] r;
        r = '0;
        for (int k = 0; k < b; k++)
            for (int j = 0; j < 4; j++)
                r[32*k+31-8*j -: 8] = shadow[wrap(a, 4*k+j)];
        return r;
    endfunction

    function automatic logic [LW*DW-1:0] rnd_line();
        logic [LW*DW-1:0] r;
        for (int k = 0; k < LW; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [2:0] rnd_dt();
        case ($urandom_range(0, 2))
            0:       return ONE_BYTE;
            1:       return TWO_BYTE;
            default: return FOUR_BYTE;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [LW*DW-1:0] act,
                       input logic [LW*DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Main memory: commands sampled on the clock, response one cycle later.
    always @(posedge clk) begin
        cmd_t c;
        int   nb;
        if (rst) begin
            mif.mem_status <= MEM_RESTING;
            mif.mem_rdata  <= '0;
        end else begin
            mif.mem_status <= MEM_RESTING;
            c.addr = mif.mem_addr;
            c.dt   = mif.mem_data_type;
            c.kind = 2'd0;
            if (mif.mem_i_signal == MEM_READ && mif.mem_d_signal == MEM_NOP)
                c.kind = 2'd1;
            else if (mif.mem_d_signal == MEM_READ && mif.mem_i_signal == MEM_NOP)
                c.kind = 2'd2;
            else if (mif.mem_d_signal == MEM_WRITE && mif.mem_i_signal == MEM_NOP)
                c.kind = 2'd3;
            if (mif.mem_i_signal != MEM_NOP || mif.mem_d_signal != MEM_NOP) begin
                cmd_log.push_back(c);
                mif.mem_status <= MEM_DONE;
                if (c.kind == 2'd1 || c.kind == 2'd2)
                    mif.mem_rdata <= {store[c.addr], store[wrap(c.addr, 1)],
                                      store[wrap(c.addr, 2)], store[wrap(c.addr, 3)]};
                else if (c.kind == 2'd3) begin
                    nb = bytes_of(c.dt);
                    for (int j = 0; j < nb; j++)
                        store[wrap(c.addr, j)] = mif.mem_wdata[31-8*j -: 8];
                end
            end
        end
    end

    task automatic check_done(input bit is_i);
        exp_t             e;
        logic [LW*DW-1:0] act;
        logic [LW*DW-1:0] msk;
        logic [1:0]       kind;
        bit               ok;
        checks++;
        if (!(is_i ? i_req : d_req)) begin
            errors++;
            $display("FAIL done_req: %s done with req low", is_i ? "i" : "d");
        end
        checks++;
        if (is_i ? exp_i.size() == 0 : exp_d.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: %s done with nothing pending", is_i ? "i" : "d");
            cmd_log.delete();
            return;
        end
        e = is_i ? exp_i.pop_front() : exp_d.pop_front();
        order = {order, is_i ? "i" : "d"};
        checks++;
        if (cmd_log.size() != e.beats) begin
            errors++;
            $display("FAIL beats: got %0d want %0d", cmd_log.size(), e.beats);
        end
        kind = is_i ? 2'd1 : (e.we ? 2'd3 : 2'd2);
        ok = 1'b1;
        for (int k = 0; k < e.beats && k < cmd_log.size(); k++) begin
            if (cmd_log[k].kind != kind || cmd_log[k].addr != wrap(e.addr, 4*k))
                ok = 1'b0;
            if (e.we && cmd_log[k].dt != e.dt) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmds: first got kind %0d addr %0h dt %0d want kind %0d addr %0h dt %0d",
                     cmd_log.size() > 0 ? cmd_log[0].kind : 2'd0,
                     cmd_log.size() > 0 ? cmd_log[0].addr : '0,
                     cmd_log.size() > 0 ? cmd_log[0].dt : 3'd0,
                     kind, e.addr, e.dt);
        end
        if (!e.we) begin
            act = is_i ? i_rdata : d_rdata;
            msk = (e.beats >= 8) ? {(LW*DW){1'b1}}
                : ((LW*DW)'(1) << (32*e.beats)) - (LW*DW)'(1);
            chk(is_i ? "i_line" : "d_line", act & msk, e.rdata & msk);
        end else begin
            ok = 1'b1;
            for (int k = 0; k < 4*e.beats; k++)
                if (store[wrap(e.addr, k)] !== shadow[wrap(e.addr, k)]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wr_store: got %0h want %0h at %0h",
                         store[e.addr], shadow[e.addr], e.addr);
            end
        end
        cmd_log.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (i_done) check_done(1'b1);
            if (d_done) check_done(1'b0);
        end
    end

    task automatic wait_done(input bit is_i, input int beats, input bit lat);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(is_i ? i_done : d_done) && cyc < 400);
        if (!(is_i ? i_done : d_done)) begin
            checks++;
            errors++;
            $display("FAIL timeout: %s done not seen in %0d cycles", is_i ? "i" : "d", cyc);
        end else if (lat) begin
            checks++;
            if (cyc != 2*beats+1) begin
                errors++;
                $display("FAIL latency: got %0d want %0d", cyc, 2*beats+1);
            end
        end
        @(posedge clk);
        #1;
        if (is_i) i_req = 1'b0;
        else d_req = 1'b0;
    endtask

    task automatic do_i(input logic [AW-1:0] a, input logic [3:0] n,
                        input bit lat, input int gap);
        exp_t e;
        e.we    = 1'b0;
        e.beats = beats_of(n);
        e.addr  = a;
        e.dt    = FOUR_BYTE;
        e.rdata = line_of(a, e.beats);
        exp_i.push_back(e);
        i_addr = a;
        i_len  = n;
        i_req  = 1'b1;
        wait_done(1'b1, e.beats, lat);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_d(input logic [AW-1:0] a, input logic [3:0] n,
                        input bit we, input logic [2:0] dt,
                        input logic [LW*DW-1:0] wd, input bit lat, input int gap);
        exp_t e;
        int   nb;
        e.we    = we;
        e.beats = beats_of(n);
        e.addr  = a;
        e.dt    = (e.beats == 1) ? dt : FOUR_BYTE;
        e.rdata = '0;
        if (we) begin
            nb = (e.beats == 1) ? bytes_of(dt) : 4;
            for (int k = 0; k < e.beats; k++)
                for (int j = 0; j < nb; j++)
                    shadow[wrap(a, 4*k+j)] = wd[32*k+31-8*j -: 8];
        end else begin
            e.rdata = line_of(a, e.beats);
        end
        exp_d.push_back(e);
        d_addr      = a;
        d_len       = n;
        d_we        = we;
        d_data_type = dt;
        d_wdata     = wd;
        d_req       = 1'b1;
        wait_done(1'b0, e.beats, lat);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [AW-1:0] rnd_ia();
        return AW'($urandom_range(0, 32'h7F00));
    endfunction

    function automatic logic [AW-1:0] rnd_da();
        return AW'(32'h8000 + $urandom_range(0, 32'h7F00));
    endfunction

    initial begin
        int cyc;
        for (int a = 0; a < (1<<AW); a++) begin
            store[a]  = 8'($urandom);
            shadow[a] = store[a];
        end
        for (int a = 0; a < 8; a++) begin
            store[a]  = 8'(a + 1);
            shadow[a] = 8'(a + 1);
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_i_sig", mif.mem_i_signal, MEM_NOP);
        chk("rst_d_sig", mif.mem_d_signal, MEM_NOP);
        chk("rst_addr", mif.mem_addr, '0);
        chk("rst_i_done", i_done, 1'b0);
        chk("rst_d_done", d_done, 1'b0);
        chk("rst_i_rdata", i_rdata, '0);

        do_i(17'h00000, 4'd2, 1'b1, 0);
        chk("inst_line", i_rdata[63:0], 64'h05060708_01020304);

        do_d(17'h01000, 4'd2, 1'b1, FOUR_BYTE,
             {192'h0, 32'h11223344, 32'hAABBCCDD}, 1'b1, 0);
        chk("wr_bytes", {store[17'h1000], store[17'h1001], store[17'h1002], store[17'h1003],
                         store[17'h1004], store[17'h1005], store[17'h1006], store[17'h1007]},
            64'hAABBCCDD_11223344);
        do_d(17'h01000, 4'd2, 1'b0, FOUR_BYTE, '0, 1'b1, 0);
        chk("rd_back", d_rdata[63:0], 64'h11223344_AABBCCDD);

        do_d(17'h02003, 4'd1, 1'b1, ONE_BYTE, {224'h0, 32'h5A000000}, 1'b1, 0);
        chk("byte_2003", store[17'h2003], 8'h5A);

        do_i(17'h00200, 4'd0, 1'b1, 0);
        do_d(17'h03000, 4'd15, 1'b0, FOUR_BYTE, '0, 1'b1, 0);
        do_i(17'h1FFFC, 4'd2, 1'b1, 0);
        chk("wrap_beat1", i_rdata[63:32], 32'h01020304);

        i_addr = 17'h00400;
        i_len  = 4'd4;
        i_req  = 1'b1;
        cyc    = 0;
        while (cmd_log.size() < 2 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_reach_beat1", cmd_log.size() >= 2, 1'b1);
        rst   = 1'b1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_i_sig", mif.mem_i_signal, MEM_NOP);
        chk("mid_rst_d_sig", mif.mem_d_signal, MEM_NOP);
        chk("mid_rst_i_done", i_done, 1'b0);
        chk("mid_rst_i_rdata", i_rdata, '0);
        cmd_log.delete();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        do_i(17'h00010, 4'd3, 1'b1, 0);

        order = "";
        fork
            begin
                for (int n = 0; n < 9; n++)
                    do_d(rnd_da(), 4'($urandom_range(0, 15)), 1'($urandom),
                         rnd_dt(), rnd_line(), 1'b0, 0);
            end
            begin
                for (int n = 0; n < 2; n++)
                    do_i(rnd_ia(), 4'($urandom_range(0, 15)), 1'b0, 0);
            end
        join
        checks++;
        if (order.substr(0, 9) != "ddddiddddi") begin
            errors++;
            $display("FAIL grant_order: got %s want ddddiddddi...", order);
        end

        fork
            begin
                for (int n = 0; n < 35; n++)
                    do_d(rnd_da(), 4'($urandom_range(0, 15)), 1'($urandom),
                         rnd_dt(), rnd_line(), 1'b0, $urandom_range(0, 3));
            end
            begin
                for (int n = 0; n < 25; n++)
                    do_i(rnd_ia(), 4'($urandom_range(0, 15)), 1'b0,
                         $urandom_range(0, 3));
            end
        join
        repeat (4) @(posedge clk);
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            errors++;
            $display("FAIL leftover: i %0d d %0d pending", exp_i.size(), exp_d.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
